calc_btn_cond: RTL and testbench
================================

CALC_BTN_COND -- requirements
Module: calc_btn_cond

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of consecutive stable synchronized cycles needed to accept a level change (minimum 2).
REQ-002 Parameter SYNC_STAGES, default 2, is the depth of the input synchronizer flop chain (minimum 2).
REQ-003 Parameter REPEAT_DELAY, default 50000000, is the number of cycles from the accept pulse to the first auto-repeat pulse.
REQ-004 Parameter REPEAT_PERIOD, default 10000000, is the number of cycles between subsequent auto-repeat pulses.
REQ-005 Parameter REPEAT_MASK, default 5'b01000, selects the channels eligible for auto-repeat (btnd only).
REQ-006 Port clk, input, 1: the single system clock; all state SHALL be on its rising edge.
REQ-007 Port resetn, input, 1: asynchronous, active-low reset.
REQ-008 Port btn_raw, input, 5: raw, bouncy, asynchronous buttons, index order {btnu, btnd, btnl, btnc, btnr} from bit 4 down to bit 0.
REQ-009 Port btn_level, output, 5: debounced button levels.
REQ-010 Port btn_pulse, output, 5: one-cycle rising-edge (press) pulses that feed calc (btnd pulse to the accumulator update, btnu pulse to reset).

Function
REQ-011 Each channel SHALL pass through its own SYNC_STAGES-deep synchronizer, giving signal s.
REQ-012 Each channel SHALL keep a counter that clears whenever s equals btn_level and increments whenever s differs.
REQ-013 When s differs and the counter equals DEBOUNCE_CYCLES-1, the channel SHALL toggle btn_level and clear the counter on that edge.
REQ-014 A raw change held steady SHALL appear on btn_level at the (SYNC_STAGES+DEBOUNCE_CYCLES)th rising edge, counting the first edge that samples the new value as edge 1.
REQ-015 Any synchronized glitch shorter than DEBOUNCE_CYCLES cycles SHALL clear the counter and SHALL leave btn_level unchanged.
REQ-016 btn_pulse[i] SHALL be registered, high for exactly one cycle, and asserted on the same edge that btn_level[i] rises 0->1.
REQ-017 A release (1->0) SHALL be debounced identically and SHALL generate no pulse.
REQ-018 Channels SHALL be fully independent, and simultaneous presses SHALL produce simultaneous pulses.
REQ-019 Counter width SHALL be $clog2 of the largest of DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD, with no wrap-around reachable.

Reset
REQ-020 While resetn=0, all synchronizer flops, counters, btn_level and btn_pulse SHALL be 0, asynchronously.
REQ-021 Reset asserted mid-debounce or mid-repeat SHALL discard the progress, and no pulse SHALL be emitted on release of reset.
REQ-022 A button already held at reset release SHALL be debounced from zero and SHALL emit one press pulse after the REQ-014 latency.

Configuration
REQ-023 With macro CALC_BTN_AUTOREPEAT_EN defined, a REPEAT_MASK channel held high SHALL pulse REPEAT_DELAY cycles after its accept pulse, then every REPEAT_PERIOD cycles until btn_level falls.
REQ-024 A release during the repeat wait SHALL cancel the pending repeat, and a re-press SHALL restart at REPEAT_DELAY.
REQ-025 With CALC_BTN_AUTOREPEAT_EN undefined, no repeat logic SHALL be synthesized, and each press SHALL yield exactly one pulse.

Structure
REQ-026 Package calc_pkg SHALL hold NUM_BTN=5 and the index constants BTN_R=0, BTN_C=1, BTN_L=2, BTN_D=3, BTN_U=4.
REQ-027 The block SHALL contain one sub-module, btn_debounce (synchronizer, counter and pulse for one channel, with optional repeat), instantiated NUM_BTN times by a generate loop.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, REPEAT_DELAY=8, REPEAT_PERIOD=3, 20 ns clock)
REQ-028 resetn low with btn_raw=5'h1F -> btn_level=0 and btn_pulse=0; after release, pulse[4:0]=5'h1F once, at edge 6.
REQ-029 btn_raw[3] high steady from edge 1 -> btn_level[3]=1 and btn_pulse[3]=1 at edge 6 only; pulse back to 0 at edge 7.
REQ-030 btn_raw[1] toggling 1,0,1,0 every cycle, then steady 1 -> no pulse during bounce; a single pulse 6 edges after the last toggle.
REQ-031 Hold btn_raw[0] high, then low for 3 cycles, then high again -> btn_level[0] stays 1, no second pulse.
REQ-032 With CALC_BTN_AUTOREPEAT_EN, hold btn_raw[3] for 20 cycles after the accept pulse -> pulses at +0, +8, +11, +14, +17; btn_raw[2] held the same way -> a single pulse.
REQ-033 resetn pulsed low at counter=2 mid-press -> all outputs 0; after release, the full 6-edge latency is measured again before the pulse.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared constants for the calculator button conditioner
package calc_pkg;

  localparam int NUM_BTN = 5;
  localparam int BTN_R   = 0;
  localparam int BTN_C   = 1;
  localparam int BTN_L   = 2;
  localparam int BTN_D   = 3;
  localparam int BTN_U   = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/calc_btn_cond_if.sv
// rtl/calc_btn_cond_if.sv - raw button inputs and conditioned level/pulse outputs
interface calc_btn_cond_if;
  import calc_pkg::*;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_pulse;

  modport master (output btn_raw, input btn_level, input btn_pulse);
  modport slave  (input btn_raw, output btn_level, output btn_pulse);
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - one button channel: synchronizer, debounce counter, press pulse
// Auto-repeat on this channel exists only with CALC_BTN_AUTOREPEAT_EN and REPEAT_EN set.
module btn_debounce
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_raw_i,
  output logic btn_level_o,
  output logic btn_pulse_o
);

  localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   level_q;
  logic                   pulse_q;
  logic                   s;
  logic                   accept;
  logic                   rep_fire;

  assign s      = sync_q[SYNC_STAGES-1];
  assign accept = (s != level_q) && (cnt_q == DB_LAST);

`ifdef CALC_BTN_AUTOREPEAT_EN
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

  logic [CW-1:0] rep_cnt_q;
  logic          rep_first_q;

  // A falling accept wins over a due repeat so no pulse is emitted on release.
  assign rep_fire = REPEAT_EN && level_q && !accept &&
                    (rep_cnt_q == (rep_first_q ? RD_LAST : RP_LAST));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else if (!REPEAT_EN || !level_q || accept) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else if (rep_fire) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_q + 1'b1;
    end
  end
`else
  logic unused_repeat_en;
  assign unused_repeat_en = REPEAT_EN;
  assign rep_fire         = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw_i};
      if (s == level_q || accept) cnt_q <= '0;
      else                        cnt_q <= cnt_q + 1'b1;
      if (accept) level_q <= ~level_q;
      pulse_q <= (accept && s) || rep_fire;
    end
  end

  assign btn_level_o = level_q;
  assign btn_pulse_o = pulse_q;

endmodule

// File: rtl/calc_btn_cond.sv
// rtl/calc_btn_cond.sv - five-channel button conditioner feeding calc
// Optional auto-repeat on REPEAT_MASK channels: define CALC_BTN_AUTOREPEAT_EN.
module calc_btn_cond
  import calc_pkg::*;
#(
  parameter int                 DEBOUNCE_CYCLES = 1000000,
  parameter int                 SYNC_STAGES     = 2,
  parameter int                 REPEAT_DELAY    = 50000000,
  parameter int                 REPEAT_PERIOD   = 10000000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 5'b01000
) (
  input  logic           clk,
  input  logic           resetn,
  calc_btn_cond_if.slave bus
);

  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] pulse;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_debounce (
      .clk         (clk),
      .resetn      (resetn),
      .btn_raw_i   (bus.btn_raw[i]),
      .btn_level_o (level[i]),
      .btn_pulse_o (pulse[i])
    );
  end

  assign bus.btn_level = level;
  assign bus.btn_pulse = pulse;

endmodule

// File: tb/tb_calc_btn_cond.sv
// tb/tb_calc_btn_cond.sv - scoreboard bench for calc_btn_cond (directed + random)
module tb_calc_btn_cond;
  import calc_pkg::*;

  localparam int DB = 4;
  localparam int SS = 2;
  localparam int RD = 8;
  localparam int RP = 3;
  localparam logic [NUM_BTN-1:0] MASK = 5'b01000;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;

  calc_btn_cond_if bus();

  calc_btn_cond #(
    .DEBOUNCE_CYCLES (DB),
    .SYNC_STAGES     (SS),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .REPEAT_MASK     (MASK)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #10 clk = ~clk;

  typedef struct {
    int                 cyc;
    logic [NUM_BTN-1:0] vec;
  } exp_t;

  exp_t               exp_q[$];
  logic [NUM_BTN-1:0] raw_pipe[$];
  bit                 s_hist[NUM_BTN][$];
  logic [NUM_BTN-1:0] m_level = '0;
  int                 acc_edge[NUM_BTN];

  task automatic model_reset();
    raw_pipe.delete();
    for (int i = 0; i < SS; i++) raw_pipe.push_back('0);
    for (int c = 0; c < NUM_BTN; c++) begin
      s_hist[c].delete();
      acc_edge[c] = 0;
    end
    m_level = '0;
    exp_q.delete();
  endtask

  // Reference: a level flips once the last DB synchronized samples all disagree with it.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      model_reset();
    end else begin
      logic [NUM_BTN-1:0] s_now;
      logic [NUM_BTN-1:0] pv;
      bit                 all_diff;
      edge_n++;
      s_now = raw_pipe.pop_front();
      raw_pipe.push_back(bus.btn_raw);
      pv = '0;
      for (int c = 0; c < NUM_BTN; c++) begin
        s_hist[c].push_back(s_now[c]);
        if (s_hist[c].size() > DB) void'(s_hist[c].pop_front());
        all_diff = (s_hist[c].size() == DB);
        for (int k = 0; k < s_hist[c].size(); k++)
          if (s_hist[c][k] == m_level[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[c] = ~m_level[c];
          s_hist[c].delete();
          if (m_level[c]) begin
            pv[c] = 1'b1;
            acc_edge[c] = edge_n;
          end
        end
`ifdef CALC_BTN_AUTOREPEAT_EN
        else if (MASK[c] && m_level[c] && (edge_n - acc_edge[c]) >= RD &&
                 ((edge_n - acc_edge[c] - RD) % RP) == 0) begin
          pv[c] = 1'b1;
        end
`endif
      end
      if (pv != '0) exp_q.push_back('{cyc: edge_n, vec: pv});
    end
  end

  always @(negedge clk) begin
    if (!resetn) begin
      checks++;
      if (bus.btn_level !== '0 || bus.btn_pulse !== '0) begin
        errors++;
        $display("FAIL reset_outputs: level=%b pulse=%b, expected 0", bus.btn_level, bus.btn_pulse);
      end
    end else begin
      checks++;
      if (bus.btn_level !== m_level) begin
        errors++;
        $display("FAIL level: edge %0d got %b expected %b", edge_n, bus.btn_level, m_level);
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < edge_n) begin
        errors++;
        $display("FAIL missing_pulse: edge %0d got none expected %b", exp_q[0].cyc, exp_q[0].vec);
        void'(exp_q.pop_front());
      end
      if (bus.btn_pulse !== '0) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0].cyc != edge_n) begin
          errors++;
          $display("FAIL unexpected_pulse: edge %0d got %b expected none", edge_n, bus.btn_pulse);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (bus.btn_pulse !== e.vec) begin
            errors++;
            $display("FAIL pulse_vec: edge %0d got %b expected %b", edge_n, bus.btn_pulse, e.vec);
          end
        end
      end
    end
  end

  task automatic drive(input logic [NUM_BTN-1:0] v);
    @(posedge clk);
    #3;
    bus.btn_raw = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic measure(input logic [NUM_BTN-1:0] m, input int start, input int want, input string name);
    int got;
    got = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((bus.btn_pulse & m) != '0) begin
        got = edge_n - start;
        break;
      end
    end
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: latency %0d expected %0d", name, got, want);
    end
  endtask

  task automatic collect(input int ch, input int n_wanted, input int w0, input int w1,
                         input int w2, input int w3, input int w4, input string name);
    int offs[$];
    int want[5];
    int acc;
    bit bad;
    want = '{w0, w1, w2, w3, w4};
    acc = edge_n;
    offs.push_back(0);
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (bus.btn_pulse[ch]) offs.push_back(edge_n - acc);
    end
    bad = (offs.size() != n_wanted);
    for (int i = 0; i < n_wanted && i < offs.size(); i++)
      if (offs[i] != want[i]) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s: %0d pulses (second at +%0d) expected %0d pulses", name, offs.size(),
               (offs.size() > 1) ? offs[1] : -1, n_wanted);
    end
  endtask

  initial begin
    #(20 * 20000);
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int st;
    int cnt;
    bit calm;
    bus.btn_raw = '1;
    resetn = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);

    // buttons held through reset release: one simultaneous press pulse at edge 6
    #3 resetn = 1'b1;
    st = edge_n;
    measure(5'h1F, st, 6, "held_at_reset");
    drive('0);
    idle(12);

    drive(5'b01000);
    st = edge_n;
    measure(5'b01000, st, 6, "press_d");
    @(negedge clk);
    checks++;
    if (bus.btn_pulse[BTN_D] !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width: pulse[3]=%b one cycle later, expected 0", bus.btn_pulse[BTN_D]);
    end
    drive('0);
    idle(12);

    drive(5'b00010); drive(5'b00000); drive(5'b00010); drive(5'b00000);
    drive(5'b00010);
    st = edge_n;
    measure(5'b00010, st, 6, "bounce_c");
    drive('0);
    idle(12);

    drive(5'b00001);
    st = edge_n;
    measure(5'b00001, st, 6, "press_r");
    drive('0); drive('0); drive('0);
    drive(5'b00001);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.btn_pulse[BTN_R]) cnt++;
    end
    checks++;
    if (cnt != 0 || bus.btn_level[BTN_R] !== 1'b1) begin
      errors++;
      $display("FAIL glitch_r: %0d pulses level=%b, expected 0 pulses level=1", cnt, bus.btn_level[BTN_R]);
    end
    drive('0);
    idle(12);

    drive(5'b10000);
    repeat (4) @(posedge clk);
    #3 resetn = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #3 resetn = 1'b1;
    st = edge_n;
    measure(5'b10000, st, 6, "reset_mid_press");
    drive('0);
    idle(12);

    drive(5'b01000);
    st = edge_n;
    measure(5'b01000, st, 6, "repeat_accept_d");
`ifdef CALC_BTN_AUTOREPEAT_EN
    collect(BTN_D, 5, 0, 8, 11, 14, 17, "repeat_d");
`else
    collect(BTN_D, 1, 0, 0, 0, 0, 0, "single_d");
`endif
    drive('0);
    idle(15);

    drive(5'b00100);
    st = edge_n;
    measure(5'b00100, st, 6, "repeat_accept_l");
    collect(BTN_L, 1, 0, 0, 0, 0, 0, "no_repeat_l");
    drive('0);
    idle(15);

    calm = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #3;
      if ((n % 250) == 0) calm = ~calm;
      resetn = ($urandom_range(0, 499) != 0);
      for (int c = 0; c < NUM_BTN; c++)
        if ($urandom_range(0, calm ? 13 : 2) == 0) bus.btn_raw[c] = ~bus.btn_raw[c];
    end

    #0 resetn = 1'b1;
    drive('0);
    idle(25);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected pulses never seen, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
